sample_ctrl: RTL and testbench

- Control FSM for the Lab 5 sample-averaging path.
- Accepts a synchronized data-ready level from the input synchronizer.
- Sequences register-file operations in the datapath: load the new sample, shift the 4-sample window, sum the window into R0.
- Emits one cnt_up pulse per accepted sample and a clear pulse on error. Both go directly to the downstream 1000-sample counter.

---
 rtl/sample_ctrl.sv | 99 +++++++++
 tb/tb_sample_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/sample_ctrl.sv
// Sample-averaging control FSM: sequences load / window-shift / sum operations
// on the datapath register file and pulses the downstream sample counter.
module sample_ctrl #(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic              dr,
    input  logic              overflow,
    output logic              cnt_up,
    output logic              clear,
    output logic              modwait,
    output logic [2:0]        op,
    output logic [ADDR_W-1:0] src1,
    output logic [ADDR_W-1:0] src2,
    output logic [ADDR_W-1:0] dest,
    output logic              err
);
    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_COPY = 3'b001;
    localparam logic [2:0] OP_LOAD = 3'b010;
    localparam logic [2:0] OP_ADD  = 3'b100;

    typedef enum logic [3:0] {
        IDLE, STORE, SORT1, SORT2, SORT3, SORT4, ADD1, ADD2, ADD3, EIDLE
    } state_t;

    typedef struct packed {
        logic [2:0]        op;
        logic [ADDR_W-1:0] src1;
        logic [ADDR_W-1:0] src2;
        logic [ADDR_W-1:0] dest;
        logic              cnt_up;
        logic              err;
    } ctl_t;

    state_t state, nxt;
    ctl_t   ctl;

    // Moore decode; fields not named for a state stay at zero.
    function automatic ctl_t decode(input state_t s);
        ctl_t c;
        c    = '0;
        c.op = OP_NOP;
        case (s)
            STORE: begin c.op = OP_LOAD; c.dest = ADDR_W'(5); c.cnt_up = 1'b1; end
            SORT1: begin c.op = OP_COPY; c.src1 = ADDR_W'(2); c.dest = ADDR_W'(1); end
            SORT2: begin c.op = OP_COPY; c.src1 = ADDR_W'(3); c.dest = ADDR_W'(2); end
            SORT3: begin c.op = OP_COPY; c.src1 = ADDR_W'(4); c.dest = ADDR_W'(3); end
            SORT4: begin c.op = OP_COPY; c.src1 = ADDR_W'(5); c.dest = ADDR_W'(4); end
            ADD1:  begin c.op = OP_ADD;  c.src1 = ADDR_W'(1); c.src2 = ADDR_W'(2); end
            ADD2:  begin c.op = OP_ADD;  c.src1 = ADDR_W'(0); c.src2 = ADDR_W'(3); end
            ADD3:  begin c.op = OP_ADD;  c.src1 = ADDR_W'(0); c.src2 = ADDR_W'(4); end
            EIDLE: c.err = 1'b1;
            default: ;
        endcase
        return c;
    endfunction

    always_comb begin
        nxt = IDLE;
        case (state)
            IDLE:    nxt = dr ? STORE : IDLE;
            STORE:   nxt = dr ? SORT1 : EIDLE;
            SORT1:   nxt = SORT2;
            SORT2:   nxt = SORT3;
            SORT3:   nxt = SORT4;
            SORT4:   nxt = ADD1;
            ADD1:    nxt = overflow ? EIDLE : ADD2;
            ADD2:    nxt = overflow ? EIDLE : ADD3;
            ADD3:    nxt = overflow ? EIDLE : IDLE;
            EIDLE:   nxt = dr ? STORE : EIDLE;
            default: nxt = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they are registered yet
    // still track the current state cycle-for-cycle.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state   <= IDLE;
            ctl     <= '0;
            modwait <= 1'b0;
            clear   <= 1'b0;
        end else begin
            state   <= nxt;
            ctl     <= decode(nxt);
            modwait <= (nxt != IDLE) && (nxt != EIDLE);
            clear   <= (nxt == EIDLE) && (state != EIDLE);
        end
    end

    assign op     = ctl.op;
    assign src1   = ctl.src1;
    assign src2   = ctl.src2;
    assign dest   = ctl.dest;
    assign cnt_up = ctl.cnt_up;
    assign err    = ctl.err;
endmodule

// File: tb/tb_sample_ctrl.sv
// Bench for sample_ctrl: vector table through a scoreboard queue, then hand
// sequences for held dr, async reset and a downstream 1000-sample counter.
module tb_sample_ctrl;
    logic       clk = 1'b0;
    logic       n_reset;
    logic       dr;
    logic       overflow;
    logic       cnt_up, clear, modwait, err;
    logic [2:0] op;
    logic [3:0] src1, src2, dest;

    sample_ctrl #(.ADDR_W(4)) dut (
        .clk(clk), .n_reset(n_reset), .dr(dr), .overflow(overflow),
        .cnt_up(cnt_up), .clear(clear), .modwait(modwait), .op(op),
        .src1(src1), .src2(src2), .dest(dest), .err(err)
    );

    always #5 clk = ~clk;

    // {cnt_up, clear, modwait, err, op, src1, src2, dest}
    logic [18:0] outs;
    assign outs = {cnt_up, clear, modwait, err, op, src1, src2, dest};

    localparam logic [18:0] O_IDLE  = {4'b0000, 3'b000, 4'd0, 4'd0, 4'd0};
    localparam logic [18:0] O_STORE = {4'b1010, 3'b010, 4'd0, 4'd0, 4'd5};
    localparam logic [18:0] O_SORT1 = {4'b0010, 3'b001, 4'd2, 4'd0, 4'd1};
    localparam logic [18:0] O_SORT2 = {4'b0010, 3'b001, 4'd3, 4'd0, 4'd2};
    localparam logic [18:0] O_SORT3 = {4'b0010, 3'b001, 4'd4, 4'd0, 4'd3};
    localparam logic [18:0] O_SORT4 = {4'b0010, 3'b001, 4'd5, 4'd0, 4'd4};
    localparam logic [18:0] O_ADD1  = {4'b0010, 3'b100, 4'd1, 4'd2, 4'd0};
    localparam logic [18:0] O_ADD2  = {4'b0010, 3'b100, 4'd0, 4'd3, 4'd0};
    localparam logic [18:0] O_ADD3  = {4'b0010, 3'b100, 4'd0, 4'd4, 4'd0};
    localparam logic [18:0] O_EIDC  = {4'b0101, 3'b000, 4'd0, 4'd0, 4'd0};
    localparam logic [18:0] O_EID   = {4'b0001, 3'b000, 4'd0, 4'd0, 4'd0};

    typedef struct {
        logic        dr;
        logic        ovf;
        logic [18:0] exp;
    } vec_t;

    vec_t        tbl[$];
    logic [18:0] exp_q[$];
    logic [18:0] seq9[9];
    int          n_chk = 0;
    int          n_fail = 0;

    // Downstream 1000-sample counter model fed by the DUT pulses.
    int   cnt;
    logic one_k_samples;
    assign one_k_samples = (cnt == 1000);
    always @(posedge clk or negedge n_reset) begin
        if (!n_reset)    cnt <= 0;
        else if (clear)  cnt <= 0;
        else if (cnt_up) cnt <= cnt + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Drive inputs for one cycle; expectation for the state entered at the
    // next edge is queued now and popped once the DUT has produced it.
    task automatic step(input logic d, input logic o, input logic [18:0] e, input string nm);
        dr       = d;
        overflow = o;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        chk(nm, 32'(outs), 32'(exp_q.pop_front()));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl = '{
            // clean sample; overflow ignored in SORT/IDLE, dr ignored in ADD
            '{1'b1, 1'b0, O_STORE}, '{1'b1, 1'b0, O_SORT1}, '{1'b0, 1'b0, O_SORT2},
            '{1'b0, 1'b1, O_SORT3}, '{1'b0, 1'b0, O_SORT4}, '{1'b1, 1'b0, O_ADD1},
            '{1'b0, 1'b0, O_ADD2},  '{1'b0, 1'b0, O_ADD3},  '{1'b0, 1'b0, O_IDLE},
            '{1'b0, 1'b1, O_IDLE},
            // dr withdrawn during STORE
            '{1'b1, 1'b0, O_STORE}, '{1'b0, 1'b0, O_EIDC},  '{1'b0, 1'b0, O_EID},
            '{1'b0, 1'b1, O_EID},   '{1'b1, 1'b0, O_STORE}, '{1'b1, 1'b0, O_SORT1},
            '{1'b0, 1'b0, O_SORT2}, '{1'b0, 1'b0, O_SORT3}, '{1'b0, 1'b0, O_SORT4},
            '{1'b0, 1'b0, O_ADD1},  '{1'b0, 1'b0, O_ADD2},
            // overflow in ADD2: ADD3 never issued
            '{1'b0, 1'b1, O_EIDC},  '{1'b0, 1'b0, O_EID},
            '{1'b1, 1'b0, O_STORE}, '{1'b1, 1'b0, O_SORT1}, '{1'b0, 1'b0, O_SORT2},
            '{1'b0, 1'b0, O_SORT3}, '{1'b0, 1'b0, O_SORT4}, '{1'b0, 1'b0, O_ADD1},
            // overflow in ADD1
            '{1'b0, 1'b1, O_EIDC},
            '{1'b1, 1'b0, O_STORE}, '{1'b1, 1'b0, O_SORT1}, '{1'b0, 1'b0, O_SORT2},
            '{1'b0, 1'b0, O_SORT3}, '{1'b0, 1'b0, O_SORT4}, '{1'b0, 1'b0, O_ADD1},
            '{1'b0, 1'b0, O_ADD2},  '{1'b0, 1'b0, O_ADD3},
            // overflow in ADD3
            '{1'b0, 1'b1, O_EIDC},  '{1'b0, 1'b0, O_EID},
            '{1'b1, 1'b0, O_STORE}, '{1'b1, 1'b0, O_SORT1}, '{1'b0, 1'b0, O_SORT2},
            '{1'b0, 1'b0, O_SORT3}, '{1'b0, 1'b0, O_SORT4}, '{1'b0, 1'b0, O_ADD1},
            '{1'b0, 1'b0, O_ADD2},  '{1'b0, 1'b0, O_ADD3},  '{1'b0, 1'b0, O_IDLE}
        };
        seq9 = '{O_STORE, O_SORT1, O_SORT2, O_SORT3, O_SORT4, O_ADD1, O_ADD2, O_ADD3, O_IDLE};

        n_reset  = 1'b0;
        dr       = 1'b0;
        overflow = 1'b0;
        #2;
        chk("reset_values", 32'(outs), 32'(O_IDLE));
        @(posedge clk);
        @(posedge clk);
        #1;
        n_reset = 1'b1;

        for (int i = 0; i < tbl.size(); i++)
            step(tbl[i].dr, tbl[i].ovf, tbl[i].exp, $sformatf("vec%0d", i));

        // dr held for 20 edges: STOREs on cycles 1, 10, 19
        for (int c = 1; c <= 27; c++)
            step(c <= 20, 1'b0, seq9[(c - 1) % 9], $sformatf("hold_dr c%0d", c));

        // async reset in SORT3 takes effect without a clock edge
        step(1'b1, 1'b0, O_STORE, "rst_pre0");
        step(1'b1, 1'b0, O_SORT1, "rst_pre1");
        step(1'b0, 1'b0, O_SORT2, "rst_pre2");
        step(1'b0, 1'b0, O_SORT3, "rst_pre3");
        #3;
        n_reset = 1'b0;
        #1;
        chk("async_reset", 32'(outs), 32'(O_IDLE));
        @(negedge clk);
        n_reset = 1'b1;
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b0, O_IDLE, $sformatf("post_reset%0d", i));

        // 1000 clean samples into the downstream counter
        for (int s = 0; s < 1000; s++) begin
            dr = 1'b1;
            repeat (2) @(posedge clk);
            #1;
            dr = 1'b0;
            repeat (7) @(posedge clk);
            #1;
            if (s == 998) chk("one_k_early", 32'(one_k_samples), 32'd0);
        end
        chk("count_1000", 32'(cnt), 32'd1000);
        chk("one_k_samples", 32'(one_k_samples), 32'd1);

        // overflow in ADD2 mid-run: clear pulse empties the counter
        dr = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        dr = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        overflow = 1'b1;
        @(posedge clk);
        #1;
        overflow = 1'b0;
        chk("ovf_err_clear", 32'(outs), 32'(O_EIDC));
        @(posedge clk);
        #1;
        chk("count_cleared", 32'(cnt), 32'd0);
        chk("one_k_cleared", 32'(one_k_samples), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
